// File: rtl/decode_stage_pipelined.sv
// RV32I instruction-decode stage: register file with write-through bypass,
// immediate generation, control decode, ID-resolved branches/jumps,
// hazard detection and the registered ID/EX pipeline register.
module decode_stage_pipelined #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter bit FWD_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ifid_valid,
    input  logic [XLEN-1:0] ifid_pc,
    input  logic [31:0]     ifid_instr,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_rd,
    input  logic            mem_valid,
    input  logic            mem_mem_read,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_alu_result,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            if_flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic [4:0]      idex_rd,
    output logic [XLEN-1:0] idex_imm,
    output logic [XLEN-1:0] idex_rdata1,
    output logic [XLEN-1:0] idex_rdata2,
    output logic [3:0]      idex_alu_op,
    output logic            idex_alu_src,
    output logic            idex_mem_read,
    output logic            idex_mem_write,
    output logic [2:0]      idex_mem_size,
    output logic            idex_reg_write,
    output logic [1:0]      idex_wb_sel,
    output logic            idex_illegal
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam bit RV32E  = (NUM_REGS < 32);

    typedef enum logic [6:0] {
        OPC_LOAD = 7'd3, OPC_OPIMM = 7'd19, OPC_AUIPC = 7'd23, OPC_STORE = 7'd35,
        OPC_OP = 7'd51, OPC_LUI = 7'd55, OPC_BRANCH = 7'd99, OPC_JALR = 7'd103,
        OPC_JAL = 7'd111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3, ALU_SLTU = 4'd4,
        ALU_SRL = 4'd5, ALU_XOR = 4'd6, ALU_PASSB = 4'd7, ALU_SLL = 4'd8, ALU_SRA = 4'd9,
        ALU_SLT = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      mem_size;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic            illegal;
    } idex_t;

    // Register-register and register-immediate ALU selection; SUB only exists in register form.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    arith_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op = ALU_SLL;
            3'd2:    arith_op = ALU_SLT;
            3'd3:    arith_op = ALU_SLTU;
            3'd4:    arith_op = ALU_XOR;
            3'd5:    arith_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] regs_q [NUM_REGS];
    idex_t           idex_d, idex_q;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] funct3;
    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign funct3 = ifid_instr[14:12];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(ifid_instr[31:20]));
    assign imm_s = XLEN'($signed({ifid_instr[31:25], ifid_instr[11:7]}));
    assign imm_b = XLEN'($signed({ifid_instr[31], ifid_instr[7], ifid_instr[30:25], ifid_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ifid_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ifid_instr[31], ifid_instr[19:12], ifid_instr[20], ifid_instr[30:21], 1'b0}));

    // Register file: x0 never stored, out-of-range indices never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_we && (wb_rd != 5'd0) && (!RV32E || !wb_rd[4])) begin
            regs_q[wb_rd[REG_AW-1:0]] <= wb_data;
        end
    end

    // Register reads with same-cycle write-through from the writeback port.
    logic [XLEN-1:0] rdata1, rdata2;
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != 5'd0) rdata1 = (wb_we && wb_rd == rs1) ? wb_data : regs_q[rs1[REG_AW-1:0]];
        if (rs2 != 5'd0) rdata2 = (wb_we && wb_rd == rs2) ? wb_data : regs_q[rs2[REG_AW-1:0]];
    end

    // Control decode, immediate selection, operand usage and legality.
    logic [3:0]      alu_op;
    logic            alu_src, mem_read, mem_write, reg_write, use_rs1, use_rs2;
    logic            is_branch, is_jal, is_jalr, dec_illegal;
    logic [2:0]      mem_size;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] imm;
    always_comb begin
        alu_op = ALU_AND; alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; mem_size = 3'd0;
        wb_sel = 2'd0; imm = '0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP:     begin alu_op = arith_op(funct3, ifid_instr[30], 1'b1);
                              reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OPIMM:  begin alu_op = arith_op(funct3, ifid_instr[30], 1'b0);
                              alu_src = 1'b1; reg_write = 1'b1; use_rs1 = 1'b1; imm = imm_i; end
            OPC_LOAD:   begin alu_op = ALU_ADD; alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
                              wb_sel = 2'd1; use_rs1 = 1'b1; imm = imm_i; mem_size = funct3;
                              dec_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7); end
            OPC_STORE:  begin alu_op = ALU_ADD; alu_src = 1'b1; mem_write = 1'b1; use_rs1 = 1'b1;
                              use_rs2 = 1'b1; imm = imm_s; mem_size = funct3;
                              dec_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7); end
            OPC_LUI:    begin alu_op = ALU_PASSB; alu_src = 1'b1; reg_write = 1'b1; imm = imm_u; end
            OPC_AUIPC:  begin alu_op = ALU_ADD; alu_src = 1'b1; reg_write = 1'b1; imm = imm_u; end
            OPC_JAL:    begin alu_op = ALU_ADD; reg_write = 1'b1; wb_sel = 2'd2; imm = imm_j;
                              is_jal = 1'b1; end
            OPC_JALR:   begin alu_op = ALU_ADD; reg_write = 1'b1; wb_sel = 2'd2; imm = imm_i;
                              use_rs1 = 1'b1; is_jalr = 1'b1; end
            OPC_BRANCH: begin alu_op = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
                              is_branch = 1'b1; dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3); end
            default:    dec_illegal = 1'b1;
        endcase
        if (RV32E && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (reg_write && rd[4])))
            dec_illegal = 1'b1;
    end

    // Comparator operands with MEM-stage ALU forwarding, branch condition and target.
    logic            fwd1, fwd2, br_cond, taken;
    logic [XLEN-1:0] cmp_a, cmp_b, jalr_sum;
    always_comb begin
        fwd1 = FWD_EN && mem_valid && mem_reg_write && !mem_mem_read && (mem_rd == rs1) && (rs1 != 5'd0);
        fwd2 = FWD_EN && mem_valid && mem_reg_write && !mem_mem_read && (mem_rd == rs2) && (rs2 != 5'd0);
        cmp_a = fwd1 ? mem_alu_result : rdata1;
        cmp_b = fwd2 ? mem_alu_result : rdata2;
        case (funct3)
            3'd0:    br_cond = (cmp_a == cmp_b);
            3'd1:    br_cond = (cmp_a != cmp_b);
            3'd4:    br_cond = ($signed(cmp_a) <  $signed(cmp_b));
            3'd5:    br_cond = ($signed(cmp_a) >= $signed(cmp_b));
            3'd6:    br_cond = (cmp_a <  cmp_b);
            3'd7:    br_cond = (cmp_a >= cmp_b);
            default: br_cond = 1'b0;
        endcase
        taken = is_branch ? br_cond : (is_jal || is_jalr);
        jalr_sum = cmp_a + imm;
        redirect_pc = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ifid_pc + imm);
    end

    // Hazard detection and pipeline steering outputs.
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, ctrl_rs, stall, issue;
    always_comb begin
        ex_hit1  = ex_valid && (ex_rd != 5'd0) && (ex_rd == rs1) && use_rs1;
        ex_hit2  = ex_valid && (ex_rd != 5'd0) && (ex_rd == rs2) && use_rs2;
        mem_hit1 = mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs1) && use_rs1;
        mem_hit2 = mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs2) && use_rs2;
        ctrl_rs  = is_branch || is_jalr;
        stall    = ifid_valid && (
                       (ex_mem_read && (ex_hit1 || ex_hit2)) ||
                       (ctrl_rs && ex_reg_write && (ex_hit1 || ex_hit2)) ||
                       (ctrl_rs && (mem_hit1 || mem_hit2) && (mem_mem_read || !FWD_EN)));
        issue          = ifid_valid && !stall && !dec_illegal;
        pc_write       = !stall;
        ifid_write     = !stall;
        redirect_valid = issue && taken;
        if_flush       = issue && taken;
    end

    // Next ID/EX contents: a full bubble unless a legal instruction issues.
    always_comb begin
        idex_d = '0;
        if (issue) begin
            idex_d.valid     = 1'b1;
            idex_d.pc        = ifid_pc;
            idex_d.rs1       = rs1;
            idex_d.rs2       = rs2;
            idex_d.rd        = rd;
            idex_d.imm       = imm;
            idex_d.rdata1    = rdata1;
            idex_d.rdata2    = rdata2;
            idex_d.alu_op    = alu_op;
            idex_d.alu_src   = alu_src;
            idex_d.mem_read  = mem_read;
            idex_d.mem_write = mem_write;
            idex_d.mem_size  = mem_size;
            idex_d.reg_write = reg_write;
            idex_d.wb_sel    = wb_sel;
        end
        idex_d.illegal = ifid_valid && dec_illegal && !stall;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign idex_valid     = idex_q.valid;
    assign idex_pc        = idex_q.pc;
    assign idex_rs1       = idex_q.rs1;
    assign idex_rs2       = idex_q.rs2;
    assign idex_rd        = idex_q.rd;
    assign idex_imm       = idex_q.imm;
    assign idex_rdata1    = idex_q.rdata1;
    assign idex_rdata2    = idex_q.rdata2;
    assign idex_alu_op    = idex_q.alu_op;
    assign idex_alu_src   = idex_q.alu_src;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign idex_mem_size  = idex_q.mem_size;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_wb_sel    = idex_q.wb_sel;
    assign idex_illegal   = idex_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined. Three instances share stimulus:
// 0 = default, 1 = FWD_EN off, 2 = NUM_REGS 16.
module tb_decode_stage_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ifid_valid, wb_we, ex_valid, ex_mem_read, ex_reg_write;
    logic        mem_valid, mem_mem_read, mem_reg_write;
    logic [31:0] ifid_pc, ifid_instr, wb_data, mem_alu_result;
    logic [4:0]  wb_rd, ex_rd, mem_rd;

    logic        pc_write_o[3], ifid_write_o[3], if_flush_o[3], redirect_valid_o[3];
    logic        idex_valid_o[3], idex_alu_src_o[3], idex_mem_read_o[3], idex_mem_write_o[3];
    logic        idex_reg_write_o[3], idex_illegal_o[3];
    logic [31:0] redirect_pc_o[3], idex_pc_o[3], idex_imm_o[3], idex_rdata1_o[3], idex_rdata2_o[3];
    logic [4:0]  idex_rs1_o[3], idex_rs2_o[3], idex_rd_o[3];
    logic [3:0]  idex_alu_op_o[3];
    logic [2:0]  idex_mem_size_o[3];
    logic [1:0]  idex_wb_sel_o[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage_pipelined #(
            .XLEN(32), .NUM_REGS((g == 2) ? 16 : 32), .FWD_EN(g != 1)
        ) u_dut (
            .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
            .ifid_instr(ifid_instr), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
            .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
            .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read),
            .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
            .pc_write(pc_write_o[g]), .ifid_write(ifid_write_o[g]), .if_flush(if_flush_o[g]),
            .redirect_valid(redirect_valid_o[g]), .redirect_pc(redirect_pc_o[g]),
            .idex_valid(idex_valid_o[g]), .idex_pc(idex_pc_o[g]), .idex_rs1(idex_rs1_o[g]),
            .idex_rs2(idex_rs2_o[g]), .idex_rd(idex_rd_o[g]), .idex_imm(idex_imm_o[g]),
            .idex_rdata1(idex_rdata1_o[g]), .idex_rdata2(idex_rdata2_o[g]),
            .idex_alu_op(idex_alu_op_o[g]), .idex_alu_src(idex_alu_src_o[g]),
            .idex_mem_read(idex_mem_read_o[g]), .idex_mem_write(idex_mem_write_o[g]),
            .idex_mem_size(idex_mem_size_o[g]), .idex_reg_write(idex_reg_write_o[g]),
            .idex_wb_sel(idex_wb_sel_o[g]), .idex_illegal(idex_illegal_o[g])
        );
    end

    typedef struct {
        int          dut;
        string       tag;
        bit          dc;     // skip alu_op / rd comparison
        logic        v;
        logic [3:0]  op;
        logic [31:0] r1, r2, imm;
        logic [4:0]  rd;
        logic        rw, ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_id(input int dut, input string tag, input bit dc, input logic v,
                             input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                             input logic ill);
        exp_t e;
        e.dut = dut; e.tag = tag; e.dc = dc; e.v = v; e.op = op; e.r1 = r1; e.r2 = r2;
        e.imm = imm; e.rd = rd; e.rw = rw; e.ill = ill;
        q.push_back(e);
    endtask

    task automatic bubble(input int dut, input string tag, input logic ill);
        expect_id(dut, tag, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, ill);
    endtask

    // Clock edge, compare everything the scoreboard holds, return at the falling edge.
    task automatic tick();
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            d = e.dut;
            chk({e.tag, ".valid"},  {31'd0, idex_valid_o[d]},     {31'd0, e.v});
            chk({e.tag, ".rdata1"}, idex_rdata1_o[d],             e.r1);
            chk({e.tag, ".rdata2"}, idex_rdata2_o[d],             e.r2);
            chk({e.tag, ".imm"},    idex_imm_o[d],                e.imm);
            chk({e.tag, ".rw"},     {31'd0, idex_reg_write_o[d]}, {31'd0, e.rw});
            chk({e.tag, ".ill"},    {31'd0, idex_illegal_o[d]},   {31'd0, e.ill});
            if (!e.dc) begin
                chk({e.tag, ".alu_op"}, {28'd0, idex_alu_op_o[d]}, {28'd0, e.op});
                chk({e.tag, ".rd"},     {27'd0, idex_rd_o[d]},     {27'd0, e.rd});
            end
            if (!e.v) chk({e.tag, ".pc"}, idex_pc_o[d], 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ifid_valid = 1'b0; ifid_pc = '0; ifid_instr = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        mem_valid = 1'b0; mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_rd = '0;
        mem_alu_result = '0;
        @(negedge clk);

        // Reset held two cycles with ADD x3,x1,x2 in IF/ID.
        ifid_valid = 1'b1; ifid_pc = 32'h40; ifid_instr = 32'h002081B3;
        bubble(0, "rst0", 1'b0); tick();
        bubble(0, "rst1", 1'b0); tick();

        reset = 1'b0; #1;
        chk("add.pc_write", {31'd0, pc_write_o[0]}, 32'd1);
        chk("add.redirect", {31'd0, redirect_valid_o[0]}, 32'd0);
        expect_id(0, "add", 0, 1, 4'd2, 0, 0, 0, 5'd3, 1, 0); tick();

        // Preload x1=4, x2=4; attempt to write x0.
        ifid_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd4;
        bubble(0, "wb1", 1'b0); tick();
        wb_rd = 5'd2;
        bubble(0, "wb2", 1'b0); tick();
        wb_rd = 5'd0; wb_data = 32'h1234;
        bubble(0, "wb0", 1'b0); tick();

        // ADDI x6,x0,-1: x0 still reads zero.
        wb_we = 1'b0; ifid_valid = 1'b1; ifid_instr = 32'hFFF00313;
        expect_id(0, "x0rd", 0, 1, 4'd2, 0, 0, 32'hFFFFFFFF, 5'd6, 1, 0); tick();

        // ADDI x6,x5,-1 with same-cycle write of x5, then from the stored value.
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; ifid_instr = 32'hFFF28313;
        expect_id(0, "wthru", 0, 1, 4'd2, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 5'd6, 1, 0); tick();
        wb_we = 1'b0;
        expect_id(0, "stored", 0, 1, 4'd2, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 5'd6, 1, 0); tick();

        // Load-use: LW x7 in EX, ADD x8,x7,x1 in ID.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
        ifid_instr = 32'h00138433; #1;
        chk("lu.pc_write",   {31'd0, pc_write_o[0]},   32'd0);
        chk("lu.ifid_write", {31'd0, ifid_write_o[0]}, 32'd0);
        chk("lu.if_flush",   {31'd0, if_flush_o[0]},   32'd0);
        bubble(0, "lu", 1'b0); tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; #1;
        chk("lu_go.pc_write", {31'd0, pc_write_o[0]}, 32'd1);
        expect_id(0, "lu_go", 0, 1, 4'd2, 0, 32'd4, 0, 5'd8, 1, 0); tick();

        // BEQ x1,x2,+16 at 0x100: taken with 4==4, not taken with x2 written to 5.
        ifid_pc = 32'h100; ifid_instr = 32'h00208863; #1;
        chk("beq.redirect",    {31'd0, redirect_valid_o[0]}, 32'd1);
        chk("beq.redirect_pc", redirect_pc_o[0], 32'h110);
        chk("beq.if_flush",    {31'd0, if_flush_o[0]}, 32'd1);
        chk("beq.pc_write",    {31'd0, pc_write_o[0]}, 32'd1);
        expect_id(0, "beq", 1, 1, 4'd0, 32'd4, 32'd4, 32'h10, 5'd0, 0, 0); tick();
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd5; #1;
        chk("beq_nt.redirect", {31'd0, redirect_valid_o[0]}, 32'd0);
        chk("beq_nt.if_flush", {31'd0, if_flush_o[0]}, 32'd0);
        expect_id(0, "beq_nt", 1, 1, 4'd0, 32'd4, 32'd5, 32'h10, 5'd0, 0, 0); tick();

        // JALR x1,8(x9) with ADD x9 (result 0x20) in MEM.
        wb_we = 1'b0;
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9; mem_alu_result = 32'h20;
        ifid_pc = 32'h200; ifid_instr = 32'h008480E7; #1;
        chk("jalr.redirect",     {31'd0, redirect_valid_o[0]}, 32'd1);
        chk("jalr.redirect_pc",  redirect_pc_o[0], 32'h28);
        chk("jalr.pc_write",     {31'd0, pc_write_o[0]}, 32'd1);
        chk("jalr_nf.pc_write",  {31'd0, pc_write_o[1]}, 32'd0);
        chk("jalr_nf.ifid_wr",   {31'd0, ifid_write_o[1]}, 32'd0);
        chk("jalr_nf.redirect",  {31'd0, redirect_valid_o[1]}, 32'd0);
        expect_id(0, "jalr", 1, 1, 4'd0, 0, 0, 32'd8, 5'd0, 1, 0);
        bubble(1, "jalr_nf", 1'b0); tick();
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_alu_result = '0; #1;
        chk("jalr_nf_go.pc_write",    {31'd0, pc_write_o[1]}, 32'd1);
        chk("jalr_nf_go.redirect",    {31'd0, redirect_valid_o[1]}, 32'd1);
        chk("jalr_nf_go.redirect_pc", redirect_pc_o[1], 32'h8);
        expect_id(1, "jalr_nf_go", 1, 1, 4'd0, 0, 0, 32'd8, 5'd0, 1, 0); tick();

        // Illegal opcode 0x7F: bubble plus a one-cycle illegal pulse.
        ifid_pc = 32'h300; ifid_instr = 32'h0000007F; #1;
        chk("ill.pc_write", {31'd0, pc_write_o[0]}, 32'd1);
        chk("ill.redirect", {31'd0, redirect_valid_o[0]}, 32'd0);
        bubble(0, "ill", 1'b1); tick();
        ifid_valid = 1'b0;
        bubble(0, "ill_end", 1'b0); tick();

        // ADD x20,x1,x2: illegal only for the 16-register instance.
        ifid_valid = 1'b1; ifid_instr = 32'h00208A33;
        bubble(2, "e_ill", 1'b1);
        expect_id(0, "add20", 0, 1, 4'd2, 32'd4, 32'd5, 0, 5'd20, 1, 0); tick();
        ifid_valid = 1'b0;
        bubble(2, "e_ill_end", 1'b0); tick();

        // Reset during a load-use stall: stall still visible, ID/EX held at zero.
        reset = 1'b1; ifid_valid = 1'b1; ifid_instr = 32'h00138433;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; #1;
        chk("rst_stall.pc_write", {31'd0, pc_write_o[0]}, 32'd0);
        bubble(0, "rst_stall", 1'b0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
